// File: rtl/exp_stream_driver.sv
// exp_stream_driver: stimulus/result front end for the Taylor exp() engine.
// Issues an arithmetic sequence of Q2.14 x samples to the engine over valid/ready.
// Collects Q7.25 results into an in-order show-ahead FIFO for a downstream sink.
// Issue is credit-limited so that every result the engine returns has a FIFO slot.
// Optional feature macro: EXP_DRV_CHECKSUM_EN (running 32-bit sum of collected results).
module exp_stream_driver #(
    parameter int WIDTHIN    = 16,
    parameter int WIDTHOUT   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [WIDTHIN-1:0]  i_x_start,
    input  logic [WIDTHIN-1:0]  i_x_step,
    input  logic [WIDTHIN-1:0]  i_num,
    output logic                o_x_valid,
    output logic [WIDTHIN-1:0]  o_x,
    input  logic                i_x_ready,
    input  logic                i_res_valid,
    input  logic [WIDTHOUT-1:0] i_res_y,
    output logic                o_res_ready,
    output logic                o_y_valid,
    output logic [WIDTHOUT-1:0] o_y,
    input  logic                i_y_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic [WIDTHOUT-1:0] o_checksum
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTHIN-1:0]  x_q;
    logic [WIDTHIN-1:0]  step_q;
    logic [WIDTHIN-1:0]  remaining;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [WIDTHOUT-1:0] mem [FIFO_DEPTH];

    logic        start_fire;
    logic        issue;
    logic        collect;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        credit_ok;
    logic [CW:0] occupancy;

    // Results in flight plus results parked in the FIFO must never exceed the FIFO size.
    assign occupancy  = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok  = occupancy < (CW + 1)'(FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

    assign start_fire  = (state == S_IDLE) && i_start;
    assign o_x_valid   = (state == S_RUN) && (remaining != '0) && credit_ok;
    assign o_x         = x_q;
    assign o_res_ready = !fifo_full;
    assign o_y_valid   = !fifo_empty;
    // Head is masked while empty so a stale entry never shows after reset.
    assign o_y         = fifo_empty ? '0 : mem[rd_ptr];
    assign o_busy      = (state == S_RUN) || (state == S_DRAIN);
    assign o_done      = (state == S_DONE);

    assign issue   = o_x_valid && i_x_ready;
    assign collect = i_res_valid && o_res_ready;
    assign pop     = o_y_valid && i_y_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: run until the last issue, drain until engine and FIFO are empty.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = (i_num == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issue && (remaining == WIDTHIN'(1))) state_nxt = S_DRAIN;
            S_DRAIN: if ((inflight == '0) && fifo_empty) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sample generator: latch run parameters on start, advance x (mod 2^WIDTHIN) on each issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            step_q    <= '0;
            remaining <= '0;
        end else if (start_fire) begin
            x_q       <= i_x_start;
            step_q    <= i_x_step;
            remaining <= i_num;
        end else if (issue) begin
            x_q       <= x_q + step_q;
            remaining <= remaining - WIDTHIN'(1);
        end
    end

    // Count of samples accepted by the engine whose results are not yet collected.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({issue, collect})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO control: pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (collect) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({collect, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (collect) mem[wr_ptr] <= i_res_y;
    end

`ifdef EXP_DRV_CHECKSUM_EN
    logic [WIDTHOUT-1:0] checksum;

    // Running wrap-around sum of collected results, restarted with every run.
    always_ff @(posedge clk) begin
        if (reset)           checksum <= '0;
        else if (start_fire) checksum <= '0;
        else if (collect)    checksum <= checksum + i_res_y;
    end

    assign o_checksum = checksum;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_exp_stream_driver.sv
// Self-checking bench for exp_stream_driver with a stub exp engine and a sink.
module tb_exp_stream_driver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_x_start = '0;
    logic [15:0] i_x_step = '0;
    logic [15:0] i_num = '0;
    logic        o_x_valid;
    logic [15:0] o_x;
    logic        i_x_ready = 1'b1;
    logic        i_res_valid = 1'b0;
    logic [31:0] i_res_y = '0;
    logic        o_res_ready;
    logic        o_y_valid;
    logic [31:0] o_y;
    logic        i_y_ready = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_checksum;

    always #5 clk = ~clk;

    exp_stream_driver #(.WIDTHIN(16), .WIDTHOUT(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_x_start(i_x_start), .i_x_step(i_x_step), .i_num(i_num),
        .o_x_valid(o_x_valid), .o_x(o_x), .i_x_ready(i_x_ready),
        .i_res_valid(i_res_valid), .i_res_y(i_res_y), .o_res_ready(o_res_ready),
        .o_y_valid(o_y_valid), .o_y(o_y), .i_y_ready(i_y_ready),
        .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stub engine: in-order, fixed two-cycle latency, optional input stalls.
    bit          const_mode = 1'b0;
    bit          stall_en = 1'b0;
    int          cyc = 0;
    logic [15:0] eng_x[$];
    int          eng_birth[$];

    function automatic logic [31:0] f(input logic [15:0] x);
        return const_mode ? 32'h1000_0000 : (32'h0200_0000 + {16'h0000, x});
    endfunction

    // Observations collected by the stimulus side.
    logic [15:0] issq[$];
    logic [31:0] popq[$];
    int          done_cnt = 0;

    // Reference model state used by the compare process.
    bit          chk_en = 1'b0;
    logic [15:0] m_x = '0;
    logic [15:0] m_step = '0;
    int          m_left = 0;
    int          m_inflight = 0;
    int          m_fc = 0;
    logic [31:0] m_res[$];
    logic [31:0] m_sum = '0;

    task automatic step();
        bit          hs_issue;
        bit          hs_collect;
        logic [15:0] hs_x;
        @(negedge clk);
        hs_issue   = o_x_valid && i_x_ready;
        hs_collect = i_res_valid && o_res_ready;
        hs_x       = o_x;
        if (hs_issue) issq.push_back(o_x);
        if (o_y_valid && i_y_ready) popq.push_back(o_y);
        if (o_done) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (hs_collect) begin
            void'(eng_x.pop_front());
            void'(eng_birth.pop_front());
        end
        if (hs_issue) begin
            eng_x.push_back(hs_x);
            eng_birth.push_back(cyc);
        end
        i_res_valid = (eng_x.size() > 0) && ((cyc - eng_birth[0]) >= 2);
        i_res_y     = i_res_valid ? f(eng_x[0]) : 32'h0;
        i_x_ready   = !(stall_en && ((cyc % 3) == 0));
    endtask

    task automatic start_run(input logic [15:0] xs, input logic [15:0] st, input logic [15:0] n);
        issq.delete();
        popq.delete();
        done_cnt  = 0;
        m_x       = xs;
        m_step    = st;
        m_left    = int'(n);
        m_sum     = '0;
        i_x_start = xs;
        i_x_step  = st;
        i_num     = n;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        check("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        reset   = 1'b1;
        i_start = 1'b0;
        step();
        eng_x.delete();
        eng_birth.delete();
        i_res_valid = 1'b0;
        i_res_y     = '0;
        m_res.delete();
        m_fc = 0; m_inflight = 0; m_left = 0; m_sum = '0;
        check("rst_x_valid", 32'(o_x_valid), 32'd0);
        check("rst_x", 32'(o_x), 32'd0);
        check("rst_y_valid", 32'(o_y_valid), 32'd0);
        check("rst_y", o_y, 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_checksum", o_checksum, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    // Compare process: outputs against the reference model on every cycle.
    always @(negedge clk) begin
        bit          iss_c;
        bit          col_c;
        bit          pop_c;
        if (chk_en) begin
            if (o_x_valid) begin
                check("credit", 32'((m_left > 0) && ((m_inflight + m_fc) < DEPTH)), 32'd1);
                check("x_seq", 32'(o_x), 32'(m_x));
            end
            check("res_ready", 32'(o_res_ready), 32'(m_fc < DEPTH));
            check("y_valid", 32'(o_y_valid), 32'(m_fc > 0));
            if (m_fc > 0) check("y_head", o_y, m_res[0]);
`ifdef EXP_DRV_CHECKSUM_EN
            check("checksum", o_checksum, m_sum);
`else
            check("checksum_off", o_checksum, 32'd0);
`endif
            iss_c = o_x_valid && i_x_ready;
            col_c = i_res_valid && o_res_ready;
            pop_c = o_y_valid && i_y_ready;
            if (col_c && (m_fc < m_res.size())) m_sum = m_sum + m_res[m_fc];
            if (iss_c) begin
                m_res.push_back(f(o_x));
                m_x = m_x + m_step;
                m_left--;
                m_inflight++;
            end
            if (col_c) begin
                m_inflight--;
                m_fc++;
            end
            if (pop_c) begin
                m_fc--;
                void'(m_res.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // T1: single sample at x=0 -> exp(0)=1.0 in Q7.25.
        start_run(16'h0000, 16'h0000, 16'd1);
        run_until_done(60);
        step(); step();
        check("t1_issues", 32'(issq.size()), 32'd1);
        check("t1_x0", 32'(issq[0]), 32'h0000_0000);
        check("t1_pops", 32'(popq.size()), 32'd1);
        check("t1_y0", popq[0], 32'h0200_0000);
        check("t1_done_once", 32'(done_cnt), 32'd1);

        // T2: wrap of x with engine input stalls.
        stall_en = 1'b1;
        start_run(16'hFFFF, 16'h0002, 16'd3);
        run_until_done(80);
        check("t2_issues", 32'(issq.size()), 32'd3);
        check("t2_x0", 32'(issq[0]), 32'h0000_FFFF);
        check("t2_x1", 32'(issq[1]), 32'h0000_0001);
        check("t2_x2", 32'(issq[2]), 32'h0000_0003);
        check("t2_pops", 32'(popq.size()), 32'd3);
        check("t2_y0", popq[0], 32'h0200_FFFF);
        check("t2_y1", popq[1], 32'h0200_0001);
        check("t2_y2", popq[2], 32'h0200_0003);
        stall_en = 1'b0;

        // T3: sink blocked, credit limits issue to FIFO depth.
        i_y_ready = 1'b0;
        start_run(16'h0010, 16'h0001, 16'd8);
        repeat (30) step();
        check("t3_issues_blocked", 32'(issq.size()), 32'd4);
        check("t3_x_valid_low", 32'(o_x_valid), 32'd0);
        check("t3_busy", 32'(o_busy), 32'd1);
        check("t3_pops_blocked", 32'(popq.size()), 32'd0);
        i_y_ready = 1'b1;
        run_until_done(120);
        check("t3_issues", 32'(issq.size()), 32'd8);
        check("t3_pops", 32'(popq.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_x", 32'(issq[i]), 32'h0010 + 32'(i));
            check("t3_y", popq[i], 32'h0200_0010 + 32'(i));
        end

        // T6: constant engine result, checksum restarts at run start.
        const_mode = 1'b1;
        start_run(16'h0000, 16'h0001, 16'd3);
        run_until_done(80);
        check("t6_pops", 32'(popq.size()), 32'd3);
`ifdef EXP_DRV_CHECKSUM_EN
        check("t6_checksum", o_checksum, 32'h3000_0000);
`else
        check("t6_checksum_off", o_checksum, 32'h0000_0000);
`endif
        const_mode = 1'b0;

        // T4: empty run -> done pulse the cycle after start, no issue.
        start_run(16'h1234, 16'h0001, 16'd0);
        check("t4_done_high", 32'(o_done), 32'd1);
        check("t4_busy", 32'(o_busy), 32'd0);
        step();
        check("t4_done_low", 32'(o_done), 32'd0);
        check("t4_no_issue", 32'(issq.size()), 32'd0);

        // T5: reset mid-run after two issues aborts everything.
        start_run(16'h0100, 16'h0010, 16'd8);
        for (int n = 0; n < 20 && issq.size() < 2; n++) step();
        check("t5_two_issued", 32'(issq.size() >= 2), 32'd1);
        check("t5_busy_before", 32'(o_busy), 32'd1);
        do_reset();
        step();
        check("t5_idle_busy", 32'(o_busy), 32'd0);
        check("t5_idle_x_valid", 32'(o_x_valid), 32'd0);

        // Recovery run after abort.
        start_run(16'h0005, 16'h0003, 16'd2);
        run_until_done(60);
        check("t7_pops", 32'(popq.size()), 32'd2);
        check("t7_y0", popq[0], 32'h0200_0005);
        check("t7_y1", popq[1], 32'h0200_0008);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
